// File: rtl/gold_router_ring.sv
// gold_router_ring: three-port router node for a bidirectional ring NoC.
//
// Each input (cw, ccw, pe) and each output (cw, ccw, pe) owns two packet
// buffers, one per virtual channel (VC 0 = even, VC 1 = odd). A polarity bit
// toggles every cycle: VC ~polarity faces the external links (handshakes),
// VC polarity is used for internal forwarding from input to output buffers.
// Because the two VCs never overlap in a cycle, external and internal traffic
// never touch the same buffer at the same edge.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   polarity              current polarity (0 = even, 1 = odd)
//   cwsi/cwri/cwdi        cw ring input   : send, ready, data
//   ccwsi/ccwri/ccwdi     ccw ring input  : send, ready, data
//   pesi/peri/pedi        local PE input  : send, ready, data
//   cwso/cwro/cwdo        cw ring output  : send, ready, data
//   ccwso/ccwro/ccwdo     ccw ring output : send, ready, data
//   peso/pero/pedo        local PE output : send, ready, data
//
// Header: bit 62 = direction (PE-injected packets only), bits 55:48 = hop.
// Port index used internally: 0 = cw, 1 = ccw, 2 = pe.
module gold_router_ring #(
  parameter int PACKET_SIZE = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   polarity,
  input  logic                   cwsi,
  output logic                   cwri,
  input  logic [PACKET_SIZE-1:0] cwdi,
  input  logic                   ccwsi,
  output logic                   ccwri,
  input  logic [PACKET_SIZE-1:0] ccwdi,
  input  logic                   pesi,
  output logic                   peri,
  input  logic [PACKET_SIZE-1:0] pedi,
  output logic                   cwso,
  input  logic                   cwro,
  output logic [PACKET_SIZE-1:0] cwdo,
  output logic                   ccwso,
  input  logic                   ccwro,
  output logic [PACKET_SIZE-1:0] ccwdo,
  output logic                   peso,
  input  logic                   pero,
  output logic [PACKET_SIZE-1:0] pedo
);

  localparam int DIR_BIT = 62;
  localparam int HOP_HI  = 55;
  localparam int HOP_LO  = 48;

  logic                   polarity_r;
  logic [1:0]             in_full_r  [3];
  logic [PACKET_SIZE-1:0] in_data_r  [3][2];
  logic [1:0]             out_full_r [3];
  logic [PACKET_SIZE-1:0] out_data_r [3][2];
  // Per-output round-robin pointer: 0 favours the ring input, 1 the other
  // contender (pe for the ring outputs, ccw for the pe output).
  logic [2:0]             ptr_r;

  logic                   ext_s;
  logic                   int_s;
  logic [2:0]             in_send_s;
  logic [2:0]             out_rdy_s;
  logic [PACKET_SIZE-1:0] in_din_s [3];
  logic [PACKET_SIZE-1:0] head_s   [3];
  logic [2:0]             req_s;
  logic [2:0]             hop_zero_s;
  logic                   cw_to_cw_s, cw_to_pe_s;
  logic                   ccw_to_ccw_s, ccw_to_pe_s;
  logic                   pe_to_cw_s, pe_to_ccw_s;
  logic [1:0]             gnt_cw_s, gnt_ccw_s, gnt_pe_s;
  logic [2:0]             mv_s;
  logic [2:0]             clr_s;
  logic [2:0]             contest_s;
  logic [2:0]             win_a_s;
  logic [PACKET_SIZE-1:0] mv_data_s [3];

  // Two-way arbiter: result bit 0 grants contender a, bit 1 contender b.
  function automatic logic [1:0] arb(input logic want_a, input logic want_b,
                                     input logic free, input logic ptr);
    logic [1:0] g;
    g = 2'b00;
    if (free) begin
      if (want_a && (!want_b || !ptr)) g = 2'b01;
      else if (want_b) g = 2'b10;
      else g = 2'b00;
    end else begin
      g = 2'b00;
    end
    return g;
  endfunction

  // A hop on the ring consumes one position of the hop field.
  function automatic logic [PACKET_SIZE-1:0] shift_hop(input logic [PACKET_SIZE-1:0] d);
    logic [PACKET_SIZE-1:0] r;
    r = d;
    r[HOP_HI:HOP_LO] = d[HOP_HI:HOP_LO] >> 1;
    return r;
  endfunction

  assign ext_s     = ~polarity_r;
  assign int_s     = polarity_r;
  assign in_send_s = {pesi, ccwsi, cwsi};
  assign out_rdy_s = {pero, ccwro, cwro};
  assign in_din_s[0] = cwdi;
  assign in_din_s[1] = ccwdi;
  assign in_din_s[2] = pedi;

  // Internal-VC input heads and their routing attributes.
  always_comb begin
    for (int p = 0; p < 3; p++) begin
      head_s[p]     = in_data_r[p][int_s];
      req_s[p]      = in_full_r[p][int_s];
      hop_zero_s[p] = (in_data_r[p][int_s][HOP_HI:HOP_LO] == 8'd0);
    end
  end

  assign cw_to_cw_s   = req_s[0] & ~hop_zero_s[0];
  assign cw_to_pe_s   = req_s[0] &  hop_zero_s[0];
  assign ccw_to_ccw_s = req_s[1] & ~hop_zero_s[1];
  assign ccw_to_pe_s  = req_s[1] &  hop_zero_s[1];
  assign pe_to_cw_s   = req_s[2] & ~head_s[2][DIR_BIT];
  assign pe_to_ccw_s  = req_s[2] &  head_s[2][DIR_BIT];

  // Arbitration and data movement for the internal VC.
  always_comb begin
    gnt_cw_s  = arb(cw_to_cw_s,   pe_to_cw_s,  ~out_full_r[0][int_s], ptr_r[0]);
    gnt_ccw_s = arb(ccw_to_ccw_s, pe_to_ccw_s, ~out_full_r[1][int_s], ptr_r[1]);
    gnt_pe_s  = arb(cw_to_pe_s,   ccw_to_pe_s, ~out_full_r[2][int_s], ptr_r[2]);
    mv_s      = {|gnt_pe_s, |gnt_ccw_s, |gnt_cw_s};
    clr_s     = {gnt_cw_s[1] | gnt_ccw_s[1],
                 gnt_ccw_s[0] | gnt_pe_s[1],
                 gnt_cw_s[0] | gnt_pe_s[0]};
    contest_s = {cw_to_pe_s & ccw_to_pe_s,
                 ccw_to_ccw_s & pe_to_ccw_s,
                 cw_to_cw_s & pe_to_cw_s};
    win_a_s   = {gnt_pe_s[0], gnt_ccw_s[0], gnt_cw_s[0]};
    mv_data_s[0] = gnt_cw_s[0]  ? shift_hop(head_s[0]) : shift_hop(head_s[2]);
    mv_data_s[1] = gnt_ccw_s[0] ? shift_hop(head_s[1]) : shift_hop(head_s[2]);
    // Ejected packets leave with the hop field untouched.
    mv_data_s[2] = gnt_pe_s[0]  ? head_s[0] : head_s[1];
  end

  // Buffer, polarity and pointer state.
  always_ff @(posedge clk) begin
    if (reset) begin
      polarity_r <= 1'b0;
      ptr_r      <= 3'b000;
      for (int p = 0; p < 3; p++) begin
        in_full_r[p]  <= 2'b00;
        out_full_r[p] <= 2'b00;
        for (int v = 0; v < 2; v++) begin
          in_data_r[p][v]  <= {PACKET_SIZE{1'b0}};
          out_data_r[p][v] <= {PACKET_SIZE{1'b0}};
        end
      end
    end else begin
      polarity_r <= ~polarity_r;
      for (int p = 0; p < 3; p++) begin
        if (in_send_s[p] && !in_full_r[p][ext_s]) begin
          in_full_r[p][ext_s] <= 1'b1;
          in_data_r[p][ext_s] <= in_din_s[p];
        end
        if (clr_s[p]) in_full_r[p][int_s] <= 1'b0;
        if (out_full_r[p][ext_s] && out_rdy_s[p]) out_full_r[p][ext_s] <= 1'b0;
        if (mv_s[p]) begin
          out_full_r[p][int_s] <= 1'b1;
          out_data_r[p][int_s] <= mv_data_s[p];
        end
        // Winner by contest hands priority to the loser.
        if (contest_s[p] && mv_s[p]) ptr_r[p] <= win_a_s[p];
      end
    end
  end

  assign polarity = polarity_r;
  assign cwri  = ~reset & ~in_full_r[0][ext_s];
  assign ccwri = ~reset & ~in_full_r[1][ext_s];
  assign peri  = ~reset & ~in_full_r[2][ext_s];
  assign cwso  = ~reset & out_full_r[0][ext_s];
  assign ccwso = ~reset & out_full_r[1][ext_s];
  assign peso  = ~reset & out_full_r[2][ext_s];
  assign cwdo  = reset ? {PACKET_SIZE{1'b0}} : out_data_r[0][ext_s];
  assign ccwdo = reset ? {PACKET_SIZE{1'b0}} : out_data_r[1][ext_s];
  assign pedo  = reset ? {PACKET_SIZE{1'b0}} : out_data_r[2][ext_s];

endmodule

// File: tb/tb_gold_router_ring.sv
// Testbench for gold_router_ring: directed latency/arbitration scenarios
// followed by randomized traffic, all outputs checked by a scoreboard.
module tb_gold_router_ring;

  logic        clk = 1'b0;
  logic        reset;
  logic        polarity;
  logic        cwsi, ccwsi, pesi;
  logic        cwri, ccwri, peri;
  logic [63:0] cwdi, ccwdi, pedi;
  logic        cwso, ccwso, peso;
  logic        cwro, ccwro, pero;
  logic [63:0] cwdo, ccwdo, pedo;

  always #5 clk = ~clk;

  gold_router_ring dut (
    .clk(clk), .reset(reset), .polarity(polarity),
    .cwsi(cwsi), .cwri(cwri), .cwdi(cwdi),
    .ccwsi(ccwsi), .ccwri(ccwri), .ccwdi(ccwdi),
    .pesi(pesi), .peri(peri), .pedi(pedi),
    .cwso(cwso), .cwro(cwro), .cwdo(cwdo),
    .ccwso(ccwso), .ccwro(ccwro), .ccwdo(ccwdo),
    .peso(peso), .pero(pero), .pedo(pedo)
  );

  typedef struct {
    int   out;
    int   src;
    int   cyc;
    logic vc;
  } ev_t;

  ev_t         log_q [$];
  logic [63:0] exq [3][2][3][$];   // expected packets [output][vc][source]
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        pol_m = 1'b0;        // reference polarity
  int          acc_cyc [3];
  logic        acc_vc  [3];

  wire [2:0] si_v = {pesi, ccwsi, cwsi};
  wire [2:0] ri_v = {peri, ccwri, cwri};
  wire [2:0] so_v = {peso, ccwso, cwso};
  wire [2:0] ro_v = {pero, ccwro, cwro};
  logic [63:0] di_v [3];
  logic [63:0] do_v [3];
  assign di_v[0] = cwdi;  assign di_v[1] = ccwdi; assign di_v[2] = pedi;
  assign do_v[0] = cwdo;  assign do_v[1] = ccwdo; assign do_v[2] = pedo;

  // Reference routing: output index and transformed packet.
  function automatic void route(input int src, input logic [63:0] d,
                                output int out, output logic [63:0] nd);
    int hop;
    hop = int'(d[55:48]);
    nd  = d;
    if (src == 2) begin
      out = d[62] ? 1 : 0;
      nd[55:48] = 8'(hop / 2);
    end else if (hop == 0) begin
      out = 2;
    end else begin
      out = src;
      nd[55:48] = 8'(hop / 2);
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare one logged output event: output port, source, and latency from acceptance.
  task automatic chk_ev(input string name, input int idx, input int out, input int src, input int lat);
    logic [31:0] act, exp;
    checks++;
    if (idx >= log_q.size()) begin
      errors++;
      $display("FAIL %s: event %0d missing, only %0d outputs seen", name, idx, log_q.size());
    end else begin
      act = {8'(log_q[idx].out), 8'(log_q[idx].src),
             16'((lat < 0) ? 0 : (log_q[idx].cyc - acc_cyc[src]))};
      exp = {8'(out), 8'(src), 16'((lat < 0) ? 0 : lat)};
      if (act !== exp) begin
        errors++;
        $display("FAIL %s: got out/src/lat %h expected %h", name, act, exp);
      end
    end
  endtask

  // Cycle counter and reference polarity.
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    pol_m <= reset ? 1'b0 : ~pol_m;
  end

  // Input watcher: every accepted packet becomes an expectation.
  always @(negedge clk) begin
    if (!reset) begin
      for (int s = 0; s < 3; s++) begin
        if (si_v[s] && ri_v[s]) begin
          automatic int          o;
          automatic logic [63:0] nd;
          route(s, di_v[s], o, nd);
          exq[o][~pol_m][s].push_back(nd);
          acc_cyc[s] = cyc;
          acc_vc[s]  = ~pol_m;
        end
      end
    end
  end

  // Output monitor: pops and compares on every output handshake.
  always @(negedge clk) begin
    if (cyc > 0) chk("polarity", {63'd0, polarity}, {63'd0, pol_m});
    if (!reset) begin
      for (int o = 0; o < 3; o++) begin
        if (so_v[o] && ro_v[o]) begin
          automatic logic v = ~pol_m;
          automatic bit   matched = 1'b0;
          for (int s = 0; s < 3; s++) begin
            if (!matched && exq[o][v][s].size() > 0 && exq[o][v][s][0] == do_v[o]) begin
              void'(exq[o][v][s].pop_front());
              matched = 1'b1;
              log_q.push_back('{o, s, cyc, v});
            end
          end
          checks++;
          if (!matched) begin
            errors++;
            $display("FAIL sb_out%0d: got %h on vc %0d, no matching expected packet", o, do_v[o], v);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic logic [63:0] mk(input logic dir, input logic [7:0] hop);
    logic [63:0] d;
    d = {$urandom, $urandom};
    d[62] = dir;
    d[55:48] = hop;
    return d;
  endfunction

  // Present packets on the selected inputs and hold each until accepted.
  task automatic issue(input logic [2:0] m, input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    logic [2:0] pend, done;
    pend = m;
    cwdi = a; ccwdi = b; pedi = c;
    {pesi, ccwsi, cwsi} = pend;
    for (int t = 0; t < 20 && pend != 3'b000; t++) begin
      @(negedge clk);
      done = si_v & ri_v;
      @(posedge clk); #1;
      pend = pend & ~done;
      {pesi, ccwsi, cwsi} = pend;
    end
    checks++;
    if (pend != 3'b000) begin
      errors++;
      $display("FAIL issue_timeout: pending %b expected 000", pend);
      {pesi, ccwsi, cwsi} = 3'b000;
    end
  endtask

  task automatic contend(input string name, input logic [2:0] m, input int out,
                         input int first, input int second, input logic dir);
    log_q.delete();
    issue(m, mk(1'b0, 8'd4), mk(1'b1, 8'd4), mk(dir, 8'(($urandom_range(0, 15)))));
    tick(7);
    chk_ev({name, "_first"}, 0, out, first, 2);
    chk_ev({name, "_second"}, 1, out, second, 4);
  endtask

  initial begin
    logic        p0, v, vc1;
    logic [2:0]  acc;
    int          pending;
    reset = 1'b1;
    {cwsi, ccwsi, pesi} = 3'b000;
    {cwro, ccwro, pero} = 3'b000;
    cwdi = 64'd0; ccwdi = 64'd0; pedi = 64'd0;

    // Reset state
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_polarity", {63'd0, polarity}, 64'd0);
    chk("rst_ready", {61'd0, ri_v}, 64'd0);
    chk("rst_send", {61'd0, so_v}, 64'd0);
    chk("rst_data", cwdo | ccwdo | pedo, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    {cwro, ccwro, pero} = 3'b111;
    @(negedge clk);
    chk("post_rst_ready", {61'd0, ri_v}, 64'd7);
    chk("post_rst_send", {61'd0, so_v}, 64'd0);
    p0 = polarity;
    @(negedge clk);
    chk("pol_toggle", {63'd0, polarity}, {63'd0, ~p0});
    @(posedge clk); #1;

    // No contention, both VCs
    log_q.delete();
    issue(3'b011, mk(1'b0, 8'h07), mk(1'b1, 8'h0F), 64'd0);
    tick(5);
    chk_ev("nc_cw", 0, 0, 0, 2);
    chk_ev("nc_ccw", 1, 1, 1, 2);
    vc1 = acc_vc[0];
    if (~pol_m == vc1) tick(1);
    log_q.delete();
    issue(3'b011, mk(1'b0, 8'h07), mk(1'b1, 8'h0F), 64'd0);
    tick(5);
    chk("nc_other_vc", {63'd0, acc_vc[0]}, {63'd0, ~vc1});
    chk_ev("nc_cw_odd", 0, 0, 0, 2);
    chk_ev("nc_ccw_odd", 1, 1, 1, 2);

    // PE injection
    log_q.delete();
    issue(3'b100, 64'd0, 64'd0, mk(1'b0, 8'h00));
    tick(5);
    chk_ev("inj_cw", 0, 0, 2, 2);
    chk("inj_cw_count", 64'(log_q.size()), 64'd1);
    log_q.delete();
    issue(3'b100, 64'd0, 64'd0, mk(1'b1, 8'h00));
    tick(5);
    chk_ev("inj_ccw", 0, 1, 2, 2);

    // Ejection
    log_q.delete();
    issue(3'b001, mk(1'b0, 8'h00), 64'd0, 64'd0);
    tick(5);
    chk_ev("ej_cw", 0, 2, 0, 2);
    log_q.delete();
    issue(3'b010, 64'd0, mk(1'b0, 8'h00), 64'd0);
    tick(5);
    chk_ev("ej_ccw", 0, 2, 1, 2);

    // Ring output contention, two rounds each
    contend("cont_cw_r1", 3'b101, 0, 0, 2, 1'b0);
    contend("cont_cw_r2", 3'b101, 0, 2, 0, 1'b0);
    contend("cont_ccw_r1", 3'b110, 1, 1, 2, 1'b1);
    contend("cont_ccw_r2", 3'b110, 1, 2, 1, 1'b1);

    // PE output contention
    log_q.delete();
    issue(3'b011, mk(1'b0, 8'h00), mk(1'b1, 8'h00), 64'd0);
    tick(7);
    chk_ev("cont_pe_first", 0, 2, 0, 2);
    chk_ev("cont_pe_second", 1, 2, 1, 4);

    // PE output blocked: buffers fill and ring readies drop on that VC
    log_q.delete();
    pero = 1'b0;
    issue(3'b011, mk(1'b0, 8'h00), mk(1'b1, 8'h00), 64'd0);
    v = acc_vc[0];
    tick(1);
    issue(3'b010, 64'd0, mk(1'b0, 8'h00), 64'd0);
    chk("blk_same_vc", {63'd0, acc_vc[1]}, {63'd0, v});
    tick(2);
    @(negedge clk);
    if (~pol_m != v) @(negedge clk);
    chk("blk_peso", {63'd0, peso}, 64'd1);
    chk("blk_ring_ready", {62'd0, ccwri, cwri}, 64'd0);
    @(negedge clk);
    chk("blk_other_peso", {63'd0, peso}, 64'd0);
    chk("blk_other_ready", {62'd0, ccwri, cwri}, 64'd3);
    @(posedge clk); #1;
    pero = 1'b1;
    tick(10);
    chk("blk_drain_count", 64'(log_q.size()), 64'd3);
    chk_ev("blk_drain0", 0, 2, 1, -1);
    chk_ev("blk_drain1", 1, 2, 0, -1);
    chk_ev("blk_drain2", 2, 2, 1, -1);

    // Randomized traffic with random backpressure
    for (int t = 0; t < 600; t++) begin
      @(negedge clk);
      acc = si_v & ri_v;
      @(posedge clk); #1;
      if (!cwsi || acc[0]) begin
        cwsi = ($urandom_range(0, 2) != 0);
        cwdi = mk($urandom_range(0, 1) == 1, ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 15)));
      end
      if (!ccwsi || acc[1]) begin
        ccwsi = ($urandom_range(0, 2) != 0);
        ccwdi = mk($urandom_range(0, 1) == 1, ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 15)));
      end
      if (!pesi || acc[2]) begin
        pesi = ($urandom_range(0, 2) != 0);
        pedi = mk($urandom_range(0, 1) == 1, 8'($urandom_range(0, 255)));
      end
      cwro  = ($urandom_range(0, 3) != 0);
      ccwro = ($urandom_range(0, 3) != 0);
      pero  = ($urandom_range(0, 3) != 0);
    end
    {cwsi, ccwsi, pesi} = 3'b000;
    {cwro, ccwro, pero} = 3'b111;
    tick(40);
    pending = 0;
    for (int o = 0; o < 3; o++)
      for (int vv = 0; vv < 2; vv++)
        for (int s = 0; s < 3; s++)
          pending += exq[o][vv][s].size();
    chk("drain_empty", 64'(pending), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gold_router_ring.md
Name: gold_router_ring

Overview:
- Three-port router for a bidirectional ring NoC. Ports: clockwise ring (cw), counter-clockwise ring (ccw), local processing element (pe).
- Each input and each output channel has two 64-bit buffers, one per virtual channel: even (index 0) and odd (index 1).
- A polarity bit toggles every cycle and decides which virtual channel is used on the external links and which is used for internal forwarding.
- Routing is driven by the direction and hop fields of the packet header. Each output port has a round-robin arbiter.

Parameters:
- PACKET_SIZE, 64, packet width in bits. The header bit positions below assume 64.

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- polarity  out  1  current polarity: 0 = even, 1 = odd
- cwsi  in  1  cw input send (valid)
- cwri  out  1  cw input ready
- cwdi  in  PACKET_SIZE  cw input data
- ccwsi  in  1  ccw input send (valid)
- ccwri  out  1  ccw input ready
- ccwdi  in  PACKET_SIZE  ccw input data
- pesi  in  1  pe input send (valid)
- peri  out  1  pe input ready
- pedi  in  PACKET_SIZE  pe input data
- cwso  out  1  cw output send (valid)
- cwro  in  1  cw output ready
- cwdo  out  PACKET_SIZE  cw output data
- ccwso  out  1  ccw output send (valid)
- ccwro  in  1  ccw output ready
- ccwdo  out  PACKET_SIZE  ccw output data
- peso  out  1  pe output send (valid)
- pero  in  1  pe output ready
- pedo  out  PACKET_SIZE  pe output data

Behaviour:
- Reset (sync, active-high) clears:
  - all 12 buffers to full=0, data=0;
  - polarity to 0;
  - every arbiter pointer to its default;
  - all ready and send outputs to 0 while reset is high, and all data outputs to 0.
- Polarity toggles on every clock edge after reset is released.
- Let E = ~polarity (external VC) and I = polarity (internal VC).
- Header fields:
  - bit 62: direction (0 = cw, 1 = ccw). Used only for packets entering from pe.
  - bits 55:48: hop value.
  - All other bits, including bit 63, pass through unmodified.
- Input handshake:
  - xri = ~inbuf_x[E].full.
  - When xsi && xri, xdi is written into inbuf_x[E] and its full flag is set.
  - xsi without xri is ignored; the sender must hold.
- Output handshake:
  - xso = outbuf_x[E].full; xdo = outbuf_x[E].data.
  - When xso && xro, outbuf_x[E] is cleared at the edge.
  - ri and so are combinational from the registered state and polarity.
- Internal forwarding uses only inbuf[I] → outbuf[I], at most one packet per output per cycle. Routing:
  - cw input, hop != 0 → cw output, hop shifted right by 1.
  - cw input, hop == 0 → pe output, hop unchanged.
  - ccw input, hop != 0 → ccw output, hop shifted right by 1.
  - ccw input, hop == 0 → pe output, hop unchanged.
  - pe input, dir 0 → cw output, hop shifted right by 1.
  - pe input, dir 1 → ccw output, hop shifted right by 1.
- A request is granted only if the target outbuf[I] is empty. A grant moves the data and clears inbuf[I].
- Arbitration, one pointer per output:
  - cw output: cw input vs pe input. Default favours cw.
  - ccw output: ccw input vs pe input. Default favours ccw.
  - pe output: cw input vs ccw input. Default favours cw.
  - With a single requester, that requester is granted and the pointer is unchanged.
  - When both request and one is granted, the pointer flips to favour the loser next time.
  - A losing packet stays in its buffer. It retries two cycles later, when the same VC is internal again.
- Latency:
  - Packet accepted at edge k → moved to the output buffer at edge k+1 → xso high during the cycle after edge k+1.
  - Minimum 2 cycles from acceptance to valid output.
- Backpressure: with xro=0 the output buffer stays full. The upstream input buffer then stays full, and xri drops on that VC.
- Reset mid-operation drops all buffered packets.

Test Plan:
- Reset for 5 cycles → polarity=0, all so/ri=0. After release: polarity toggles every cycle, every ri=1, every so=0.
- No contention:
  - cwsi=1, hop 0x07, dir 0, cwro=1 → cwso pulses 2 cycles after acceptance with cwdo[55:48]=0x03.
  - In parallel, ccwsi=1, dir 1, hop 0x0F → ccwdo[55:48]=0x07.
  - Repeat with the other polarity to exercise the odd buffers.
- PE injection:
  - pedi dir 0, hop 0, one-cycle pesi → one cwso with the data unchanged except hop.
  - Same with dir 1 → one ccwso.
- Ejection:
  - cwdi hop 0, pero=1 → peso with pedo == cwdi.
  - ccwdi hop 0, dir bit 0 → also ejected on pe, since direction is ignored for ring inputs.
- Contention on cw output: cwsi (hop 4) and pesi (dir 0) on the same VC cycle, cwro=1:
  - 1st round: cw packet first (hop 2), pe packet two cycles later.
  - 2nd round: pe first.
  - Same for ccw output.
- PE output contention: cw and ccw inputs both hop 0, pero=1 → cw ejected first, ccw next. Hold pero=0 → peso stays high and cwri/ccwri drop on that VC.
